// File: rtl/uart_tx_unit.sv
// uart_tx_unit: memory-mapped 8N1 UART transmitter on the MEM-stage data bus.
// One holding byte (TXD) feeds a shifter; CON exposes IE/DONE/BUSY/FULL/OVR.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line high, waiting for the holding byte
// S_START | start bit (0) for DIVISOR cycles
// S_DATA  | data bit shifter[bit_idx] for DIVISOR cycles, LSB first
// S_STOP  | stop bit (1); DONE set on terminal count
module uart_tx_unit #(
  parameter int DIVISOR = 10417
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        UART_TX,
  output logic        IRQ
);

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;
  localparam int          CW       = $clog2(DIVISOR);
  localparam logic [CW-1:0] BAUD_TC = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic [7:0]    hold;
  logic          full;
  logic          ie;
  logic          done;
  logic          ovr;
  logic          tx;

  logic txd_wr, con_wr, con_rd;
  logic baud_tc, stop_end, move, busy;

  assign txd_wr   = MemWr && (Addr == ADDR_TXD);
  assign con_wr   = MemWr && (Addr == ADDR_CON);
  assign con_rd   = MemRd && (Addr == ADDR_CON);
  assign baud_tc  = (baud_cnt == BAUD_TC);
  assign stop_end = (state == S_STOP) && baud_tc;
  // Holding byte moves to the shifter either from idle or straight out of a stop bit.
  assign move     = full && ((state == S_IDLE) || stop_end);
  assign busy     = (state != S_IDLE);

  assign UART_TX  = tx;
  assign IRQ      = done & ie;

  // Zero-latency read path for the single-cycle MEM stage.
  always_comb begin
    ReadData = '0;
    if (con_rd) ReadData = {26'b0, ovr, full, busy, done, 1'b0, ie};
  end

  // Frame sequencer; the line level is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (full) begin
            shifter <= hold;
            state   <= S_START;
            tx      <= 1'b0;
          end
        end
        S_START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
            tx       <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (full) begin
              shifter <= hold;
              state   <= S_START;
              tx      <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  // Holding register, sticky status and interrupt enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      full <= 1'b0;
      ovr  <= 1'b0;
      done <= 1'b0;
      ie   <= 1'b0;
    end else begin
      // A write on the move edge refills the slot being vacated.
      if (txd_wr && (!full || move)) begin
        hold <= WriteData[7:0];
        full <= 1'b1;
      end else if (move) begin
        full <= 1'b0;
      end

      if (txd_wr && full && !move) ovr <= 1'b1;
      else if (con_rd)             ovr <= 1'b0;

      // Set beats a coincident read-clear.
      if (stop_end)    done <= 1'b1;
      else if (con_rd) done <= 1'b0;

      if (con_wr) ie <= WriteData[0];
    end
  end

endmodule
